// File: rtl/bcd_down_counter.sv
// Cascaded multi-digit BCD decade down-counter with load, zero flag and terminal-count strobe.
// Borrow ripples through all digits in one cycle; WRAP selects hold-at-zero or roll-to-nines.
module bcd_down_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WRAP   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  zero,
  output logic                  tc,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] cnt_nxt;
  logic [W-1:0] dec_val;
  logic         zero_nxt;
  logic         tc_nxt;
  logic         err_nxt;
  logic         load_ok;
  logic         borrow;

  // Next-state: load beats en; a decrement from zero only moves when wrapping.
  always_comb begin
    cnt_nxt  = cnt;
    dec_val  = cnt;
    tc_nxt   = 1'b0;
    err_nxt  = 1'b0;
    load_ok  = 1'b1;
    borrow   = 1'b1;
    zero_nxt = zero;

    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end

    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (cnt[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end

    if (load) begin
      if (load_ok) begin
        cnt_nxt = load_val;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (zero) begin
        if (WRAP != 0) begin
          cnt_nxt = dec_val;
        end
      end else begin
        cnt_nxt = dec_val;
        tc_nxt  = (dec_val == '0);
      end
    end

    zero_nxt = (cnt_nxt == '0);
  end

  // zero is registered from the next count so it tracks cnt in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      zero     <= 1'b1;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      zero     <= zero_nxt;
      tc       <= tc_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter: hold (WRAP=0) and wrap (WRAP=1) instances share stimulus,
// checked every cycle against an integer model plus literal spot checks.
module tb_bcd_down_counter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;

  logic [W-1:0] cnt0, cnt1;
  logic         zero0, zero1, tc0, tc1, err0, err1;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(DIGITS), .WRAP(0)) u_hold (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en),
    .cnt(cnt0), .zero(zero0), .tc(tc0), .load_err(err0)
  );

  bcd_down_counter #(.DIGITS(DIGITS), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en),
    .cnt(cnt1), .zero(zero1), .tc(tc1), .load_err(err1)
  );

  function automatic bit bcd_ok(input logic [W-1:0] b);
    logic [3:0] d;
    bcd_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = b[4*i +: 4];
      if (d > 4'd9) bcd_ok = 1'b0;
    end
  endfunction

  function automatic int bcd2int(input logic [W-1:0] b);
    int v = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal model: counts are plain integers, max value 10^DIGITS - 1.
  int m0, m1;
  bit mtc0, mtc1, merr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= 0; m1 <= 0; mtc0 <= 1'b0; mtc1 <= 1'b0; merr <= 1'b0;
    end else begin
      mtc0 <= 1'b0; mtc1 <= 1'b0; merr <= 1'b0;
      if (load) begin
        if (bcd_ok(load_val)) begin
          m0 <= bcd2int(load_val);
          m1 <= bcd2int(load_val);
        end else begin
          merr <= 1'b1;
        end
      end else if (en) begin
        if (m0 > 0) begin
          m0   <= m0 - 1;
          mtc0 <= (m0 == 1);
        end
        if (m1 > 0) begin
          m1   <= m1 - 1;
          mtc1 <= (m1 == 1);
        end else begin
          m1 <= 9999;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      check("cnt_hold",  32'(cnt0),  32'(int2bcd(m0)));
      check("zero_hold", 32'(zero0), 32'(m0 == 0));
      check("tc_hold",   32'(tc0),   32'(mtc0));
      check("err_hold",  32'(err0),  32'(merr));
      check("cnt_wrap",  32'(cnt1),  32'(int2bcd(m1)));
      check("zero_wrap", 32'(zero1), 32'(m1 == 0));
      check("tc_wrap",   32'(tc1),   32'(mtc1));
      check("err_wrap",  32'(err1),  32'(merr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    run = 1'b1;
    check("reset_cnt",  32'(cnt0),  32'h0);
    check("reset_zero", 32'(zero0), 32'h1);

    // Count 0012 down to zero; tc only on arrival.
    do_load(16'h0012);
    check("load12", 32'(cnt0), 32'h0012);
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3)  check("step3",  32'(cnt0), 32'h0009);
      if (k == 11) check("tc_before_zero", 32'(tc0), 32'h0);
    end
    check("arrive_cnt",  32'(cnt0),  32'h0);
    check("arrive_tc",   32'(tc0),   32'h1);
    check("arrive_zero", 32'(zero0), 32'h1);

    // Three more enabled cycles at zero: hold vs wrap.
    for (int k = 0; k < 3; k++) tick();
    en = 1'b0;
    check("hold_cnt",  32'(cnt0), 32'h0);
    check("hold_tc",   32'(tc0),  32'h0);
    check("wrap_cnt",  32'(cnt1), 32'h9997);
    check("wrap_tc",   32'(tc1),  32'h0);

    // Full borrow ripple.
    do_load(16'h1000);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("borrow_cnt",  32'(cnt0),  32'h0999);
    check("borrow_tc",   32'(tc0),   32'h0);
    check("borrow_zero", 32'(zero0), 32'h0);

    // Rejected load keeps value and pulses load_err once.
    do_load(16'h0042);
    do_load(16'h00A5);
    check("badload_cnt", 32'(cnt0), 32'h0042);
    check("badload_err", 32'(err0), 32'h1);
    tick();
    check("err_pulse",   32'(err0), 32'h0);
    do_load(16'h0005);
    check("goodload_cnt", 32'(cnt0), 32'h0005);
    check("goodload_err", 32'(err0), 32'h0);

    // Load of zero never strobes tc.
    do_load(16'h0000);
    check("load0_tc", 32'(tc0), 32'h0);

    // Load wins over en at cnt=0001.
    do_load(16'h0001);
    load = 1'b1; load_val = 16'h0020; en = 1'b1;
    tick();
    load = 1'b0;
    check("simul_cnt", 32'(cnt0), 32'h0020);
    check("simul_tc",  32'(tc0),  32'h0);
    tick();
    en = 1'b0;
    check("after_simul", 32'(cnt0), 32'h0019);

    // Asynchronous reset mid-count.
    do_load(16'h0357);
    en = 1'b1;
    tick();
    load = 1'b1; load_val = 16'h0357; en = 1'b0;
    tick();
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_cnt",  32'(cnt0),  32'h0);
    check("areset_zero", 32'(zero0), 32'h1);
    check("areset_tc",   32'(tc0),   32'h0);
    check("areset_err",  32'(err0),  32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 2; k++) tick();
    en = 1'b0;
    check("wrap_after_reset", 32'(cnt1), 32'h9998);
    tick();

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
